mod_mul_barrett: RTL and testbench

Pipelined 28-bit modular multiplier using Barrett reduction. It computes `(a*b) mod q` for the NTT butterfly datapath and sits directly upstream of the modular adder/subtractor: the twiddle product `w*b mod q` it produces is the operand those stages combine with `a`. Throughput is one result per cycle, with a fixed 4-cycle latency, a stall input and a tag carried alongside each operand.

---
 rtl/mod_mul_barrett.sv | 151 +++++++++++++++
 tb/tb_mod_mul_barrett.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_barrett.sv
// rtl/mod_mul_barrett.sv - pipelined 28-bit Barrett modular multiplier (a*b) mod q
// Optional feature: define MODMUL_RANGE_CHECK_EN to add the sticky err output.
module mod_mul_barrett #(
  parameter int DATA_W = 28,
  parameter int TAG_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W:0]   mu,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic [TAG_W-1:0]  out_tag
`ifdef MODMUL_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int W = DATA_W;

  // Operand capture stage: the wide multiplier is fed only from flops.
  logic             v0;
  logic [W-1:0]     a0, b0;
  logic [TAG_W-1:0] tag0;

  // S1: full product.
  logic             v1;
  logic [2*W-1:0]   z1;
  logic [TAG_W-1:0] tag1;

  // S2: quotient estimate plus the low bits of z needed for the remainder.
  logic             v2;
  logic [W+1:0]     z2;
  logic [W:0]       t2;
  logic [TAG_W-1:0] tag2;

  // S3: partial remainder, known to lie in [0, 3q).
  logic             v3;
  logic [W+1:0]     r3;
  logic [TAG_W-1:0] tag3;

  logic [2*W-1:0] z_c;
  logic [W:0]     t_c;
  logic [W+1:0]   r_c;
  logic [W+1:0]   q1x, q2x;
  logic [W-1:0]   res_c;

  assign z_c = {{W{1'b0}}, a0} * {{W{1'b0}}, b0};
  assign t_c = (W+1)'(({{(W+1){1'b0}}, z1[2*W-1:W-1]} * {{(W+1){1'b0}}, mu}) >> (W+1));
  // Only the low W+2 bits of z - t*q are needed, so the product is kept at that width.
  assign r_c = z2 - ({1'b0, t2} * {2'b00, q});
  assign q1x = {2'b00, q};
  assign q2x = {1'b0, q, 1'b0};

  // Final correction: subtract 0, q or 2q to land in [0, q).
  always_comb begin
    res_c = r3[W-1:0];
    if (r3 >= q2x) begin
      res_c = W'(r3 - q2x);
    end else if (r3 >= q1x) begin
      res_c = W'(r3 - q1x);
    end
  end

  // Operand capture; stall holds every stage including this one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0   <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      tag0 <= '0;
    end else if (!stall) begin
      v0   <= in_valid;
      a0   <= a;
      b0   <= b;
      tag0 <= in_tag;
    end
  end

  // S1 product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      z1   <= '0;
      tag1 <= '0;
    end else if (!stall) begin
      v1   <= v0;
      z1   <= z_c;
      tag1 <= tag0;
    end
  end

  // S2 quotient-estimate register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      z2   <= '0;
      t2   <= '0;
      tag2 <= '0;
    end else if (!stall) begin
      v2   <= v1;
      z2   <= z1[W+1:0];
      t2   <= t_c;
      tag2 <= tag1;
    end
  end

  // S3 partial-remainder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      r3   <= '0;
      tag3 <= '0;
    end else if (!stall) begin
      v3   <= v2;
      r3   <= r_c;
      tag3 <= tag2;
    end
  end

  // S4 output register; result is zeroed whenever it is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= v3;
      out       <= v3 ? res_c : '0;
      out_tag   <= tag3;
    end
  end

`ifdef MODMUL_RANGE_CHECK_EN
  // Sticky flag for an out-of-range operand seen at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!stall && in_valid && ((a >= q) || (b >= q))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_mul_barrett.sv
// tb/tb_mod_mul_barrett.sv - scoreboard bench for mod_mul_barrett
module tb_mod_mul_barrett;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic [27:0] a = '0;
  logic [27:0] b = '0;
  logic [9:0]  in_tag = '0;
  logic [27:0] q;
  logic [28:0] mu;
  logic        out_valid;
  logic [27:0] out;
  logic [9:0]  out_tag;
`ifdef MODMUL_RANGE_CHECK_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  mod_mul_barrett #(.DATA_W(28), .TAG_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .in_tag(in_tag),
    .q(q), .mu(mu), .stall(stall), .out_valid(out_valid), .out(out), .out_tag(out_tag)
`ifdef MODMUL_RANGE_CHECK_EN
    , .err(err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [27:0] ref_mul(input logic [27:0] x, input logic [27:0] y, input logic [27:0] m);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return 28'(p % longint'(m));
  endfunction

  function automatic logic [28:0] calc_mu(input logic [27:0] m);
    longint unsigned one56;
    one56 = 64'd1 << 56;
    return 29'(one56 / longint'(m));
  endfunction

  typedef struct { logic [27:0] val; logic [9:0] tag; int acc; bit dc; } exp_t;
  typedef struct { bit v; logic [27:0] a; logic [27:0] b; logic [9:0] tag; } item_t;

  exp_t  sb[$];
  exp_t  pe;
  exp_t  me;
  item_t items[$];
  bit    stq[$];
  int    ecount = 0;
  int    run_len = 0;
  int    max_run = 0;
  int    hold_cnt = 0;
  bit    watch2 = 1'b0;

  // Scoreboard push: every accepted pair records its expected result and acceptance edge.
  always @(posedge clk) begin
    if (rst_n && !stall) begin
      ecount++;
      if (in_valid) begin
        pe.val = ref_mul(a, b, q);
        pe.tag = in_tag;
        pe.acc = ecount;
        pe.dc  = !((a < q) && (b < q));
        sb.push_back(pe);
      end
    end
  end

  // Monitor: compare presented output against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out", out, 0);
      chk("reset_out_tag", out_tag, 0);
      run_len = 0;
    end else if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (watch2 && out_tag == 10'd2) hold_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        me = sb[0];
        if (!me.dc) chk("out_value", out, me.val);
        chk("out_tag", out_tag, me.tag);
        chk("latency", ecount - me.acc, 4);
        if (!stall) void'(sb.pop_front());
      end
    end else begin
      run_len = 0;
      chk("out_zero_when_invalid", out, 0);
      if (sb.size() > 0 && (ecount - sb[0].acc) >= 4) begin
        chk("missing_out_valid", out_valid, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic add_item(input bit v, input logic [27:0] x, input logic [27:0] y, input logic [9:0] t);
    item_t it;
    it.v = v; it.a = x; it.b = y; it.tag = t;
    items.push_back(it);
  endtask

  // Drive queued items; an item is consumed only at an edge with stall low.
  task automatic run(input int ncyc);
    int idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      stall = (c < stq.size()) ? stq[c] : 1'b0;
      if (idx < items.size()) begin
        in_valid = items[idx].v;
        a        = items[idx].a;
        b        = items[idx].b;
        in_tag   = items[idx].tag;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      if (!stall) idx++;
      #1;
    end
    stall = 1'b0;
    in_valid = 1'b0;
    items.delete();
    stq.delete();
  endtask

  initial begin
    q  = 28'd268369921;
    mu = calc_mu(q);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_valid", out_valid, 0);
    rst_n = 1'b1;

    // Basic single pair.
    add_item(1, 28'd2, 28'd3, 10'd5);
    run(10);

    // Corner cases, then 10k random pairs back to back.
    max_run = 0;
    add_item(1, q - 28'd1, q - 28'd1, 10'd11);
    add_item(1, 28'd0, 28'd12345, 10'd12);
    add_item(1, q - 28'd1, 28'd1, 10'd13);
    for (int i = 0; i < 10000; i++)
      add_item(1, 28'($urandom % q), 28'($urandom % q), 10'($urandom));
    run(10003 + 8);
    chk("back_to_back_run", (max_run >= 10000), 1);

    // Stall three edges while tag 2 is at the output.
    for (int i = 0; i < 8; i++) add_item(1, 28'($urandom % q), 28'($urandom % q), 10'(i));
    for (int i = 0; i < 7; i++) stq.push_back(1'b0);
    repeat (3) stq.push_back(1'b1);
    hold_cnt = 0;
    watch2 = 1'b1;
    run(20);
    watch2 = 1'b0;
    chk("stall_hold_cycles", hold_cnt, 4);

    // Bubble pattern 1,0,0,1,1,0.
    add_item(1, 28'd100, 28'd200, 10'd21);
    add_item(0, 28'd0, 28'd0, 10'd0);
    add_item(0, 28'd0, 28'd0, 10'd0);
    add_item(1, q - 28'd2, 28'd77, 10'd22);
    add_item(1, 28'd5, q - 28'd5, 10'd23);
    add_item(0, 28'd0, 28'd0, 10'd0);
    run(14);

    // Second modulus with random bubbles and stalls; pipeline is empty here.
    q  = 28'd268435399;
    mu = calc_mu(q);
    for (int i = 0; i < 1500; i++)
      add_item(($urandom % 4) != 0, 28'($urandom % q), 28'($urandom % q), 10'($urandom));
    for (int i = 0; i < 3000; i++) stq.push_back(($urandom % 5) == 0);
    run(3000);
    run(10);

    // Reset with results in flight.
    for (int i = 0; i < 6; i++) add_item(1, 28'($urandom % q), 28'($urandom % q), 10'(i + 40));
    run(6);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out", out, 0);
    chk("midreset_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) add_item(0, 28'd0, 28'd0, 10'd0);
    add_item(1, 28'd123456, 28'd654321, 10'd99);
    run(14);

`ifdef MODMUL_RANGE_CHECK_EN
    chk("err_clear", err, 0);
    in_valid = 1'b1; a = q; b = 28'd1; in_tag = 10'd7;
    @(posedge clk);
    #1;
    chk("err_set", err, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) add_item(1, 28'($urandom % q), 28'($urandom % q), 10'(i));
    stq.push_back(1'b0); stq.push_back(1'b1); stq.push_back(1'b1);
    run(14);
    chk("err_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    chk("err_reset", err, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
